// File: rtl/leaf_out_arbiter_if.sv
// Link-side bundle of leaf_out_arbiter: user streams, destination
// config port, credit return, pause request and the BFT output packet.
// master = user/shell side driving the streams, slave = the arbiter.
interface leaf_out_arbiter_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_OUT_PORTS = 5
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0]                vld_user2interface;
  logic [NUM_OUT_PORTS-1:0]                ack_interface2user;
  logic                                    cfg_we;
  logic [NUM_PORT_BITS-1:0]                cfg_port;
  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest;
  logic                                    credit_vld;
  logic [NUM_PORT_BITS-1:0]                credit_port;
  logic                                    resend;
  logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft;
  logic                                    busy;

  modport master (
    output din_leaf_user2interface, vld_user2interface, cfg_we, cfg_port,
           cfg_dest, credit_vld, credit_port, resend,
    input  ack_interface2user, dout_leaf_interface2bft, busy
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface, cfg_we, cfg_port,
           cfg_dest, credit_vld, credit_port, resend,
    output ack_interface2user, dout_leaf_interface2bft, busy
  );
endinterface

// File: rtl/leaf_out_arbiter.sv
// Leaf output arbiter: shares the single leaf-to-BFT packet link between
// NUM_OUT_PORTS user streams. Each accepted word is wrapped with its
// destination (leaf, port) from a runtime table and a per-port 7-bit
// sequence address; destination buffer space is tracked with credits.
// Build option: define LEAF_ARB_FIXED_PRIO_EN for fixed priority (lowest
// eligible index wins, no rr pointer); default is round-robin.
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 5,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input logic               clk,
  input logic               reset,
  leaf_out_arbiter_if.slave bus
);

  localparam int DEST_W = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CRED_W = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [CRED_W-1:0] CRED_MAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
  localparam logic [CRED_W:0]   CRED_INC = (CRED_W+1)'(FREESPACE_UPDATE_SIZE);

  typedef enum logic {S_RUN, S_PAUSE} state_t;

  state_t                    state, state_nxt;
  logic [DEST_W-1:0]         tbl_dest [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0]  tbl_vld;
  logic [CRED_W-1:0]         credit [NUM_OUT_PORTS];
  logic [CRED_W-1:0]         credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]  addr [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0]  elig, sel, grant;
  logic                      found;
  logic [PACKET_BITS-1:0]    pkt;
  logic [NUM_OUT_PORTS-1:0]  ack_p1;
  logic [PACKET_BITS-1:0]    dout_p1;
  logic                      busy_p1;

`ifndef LEAF_ARB_FIXED_PRIO_EN
  localparam int PTR_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  logic [PTR_W-1:0] rr, rr_nxt, idx;
  logic [PTR_W:0]   sum;
`endif

  // A port may compete when it has data, a destination, credit, and was not
  // acked last cycle (the user is still advancing its data after an ack).
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      elig[i] = bus.vld_user2interface[i] & tbl_vld[i] & (credit[i] != '0) & ~ack_p1[i];
  end

  // Pick the winner among eligible ports.
  always_comb begin
    sel   = '0;
    found = 1'b0;
`ifdef LEAF_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!found && elig[i]) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
`else
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_OUT_PORTS; k++) begin
      sum = {1'b0, rr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_OUT_PORTS))
        sum = sum - (PTR_W+1)'(NUM_OUT_PORTS);
      idx = sum[PTR_W-1:0];
      if (!found && elig[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
`endif
  end

  // Run/pause control: grants only happen in RUN with resend low.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    case (state)
      S_RUN: begin
        if (bus.resend) state_nxt = S_PAUSE;
        else            grant     = sel;
      end
      S_PAUSE: begin
        if (!bus.resend) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Build the outgoing packet from the table entry as it stood before any
  // same-cycle config write.
  always_comb begin
    pkt = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (grant[i])
        pkt = {1'b1, tbl_dest[i], addr[i],
               bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
  end

  // Credit bookkeeping: return and consume net first, then saturate.
  always_comb begin
    logic [CRED_W:0] cs;
    cs = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      cs = {1'b0, credit[i]};
      if (bus.credit_vld && bus.credit_port == NUM_PORT_BITS'(i)) cs = cs + CRED_INC;
      if (grant[i]) cs = cs - (CRED_W+1)'(1);
      credit_nxt[i] = (cs > {1'b0, CRED_MAX}) ? CRED_MAX : cs[CRED_W-1:0];
    end
  end

`ifndef LEAF_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves to the slot just after the winner.
  always_comb begin
    rr_nxt = rr;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (grant[i])
        rr_nxt = (i == NUM_OUT_PORTS - 1) ? '0 : PTR_W'(i + 1);
  end
`endif

  // ---- stage p0 -> p1: register grant, packet and control state ----
  // Control and output state; reset drops any in-flight packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_RUN;
      ack_p1  <= '0;
      dout_p1 <= '0;
      busy_p1 <= 1'b0;
      tbl_vld <= '0;
`ifndef LEAF_ARB_FIXED_PRIO_EN
      rr      <= '0;
`endif
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= CRED_MAX;
        addr[i]   <= '0;
      end
    end else begin
      state   <= state_nxt;
      ack_p1  <= grant;
      dout_p1 <= pkt;
      busy_p1 <= |(bus.vld_user2interface & ~grant);
`ifndef LEAF_ARB_FIXED_PRIO_EN
      rr      <= rr_nxt;
`endif
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (grant[i]) addr[i] <= addr[i] + NUM_ADDR_BITS'(1);
        if (bus.cfg_we && bus.cfg_port == NUM_PORT_BITS'(i)) tbl_vld[i] <= 1'b1;
      end
    end
  end

  // Destination table payload; validity is tracked separately above.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      if (bus.cfg_we && bus.cfg_port == NUM_PORT_BITS'(i)) tbl_dest[i] <= bus.cfg_dest;
  end

  assign bus.ack_interface2user      = ack_p1;
  assign bus.dout_leaf_interface2bft = dout_p1;
  assign bus.busy                    = busy_p1;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Bench for leaf_out_arbiter: directed scenarios plus a randomized phase,
// all checked against a behavioural reference model of the link rules.
module tb_leaf_out_arbiter;
  localparam int N   = 5;
  localparam int PB  = 32;
  localparam int PKB = 49;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leaf_out_arbiter_if bus ();
  leaf_out_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  // reference model state
  int         mcred [N];
  int         maddr [N];
  bit         mval  [N];
  logic [8:0] mdest [N];
  int         mrr;
  bit         mpaused;
  logic [N-1:0] mprev;

  logic [PKB-1:0] exp_dout;
  logic [N-1:0]   exp_ack;
  logic           exp_busy;
  int             gcnt [N];
  logic [PKB-1:0] pkt0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mcred[i] = 128; maddr[i] = 0; mval[i] = 0; mdest[i] = '0;
    end
    mrr = 0; mpaused = 0; mprev = '0;
  endtask

  // Apply the link rules to the inputs presented this cycle.
  task automatic model_eval();
    int w;
    int cp;
    logic [N-1:0] v;
    w = -1;
    v = bus.vld_user2interface;
    if (!mpaused && !bus.resend) begin
      for (int k = 0; k < N; k++) begin
        int p;
`ifdef LEAF_ARB_FIXED_PRIO_EN
        p = k;
`else
        p = (mrr + k) % N;
`endif
        if (w < 0 && v[p] && mval[p] && mcred[p] > 0 && !mprev[p]) w = p;
      end
    end
    exp_ack  = '0;
    exp_dout = '0;
    if (w >= 0) begin
      exp_ack[w] = 1'b1;
      exp_dout   = {1'b1, mdest[w], 7'(maddr[w]), bus.din_leaf_user2interface[w*PB +: PB]};
      mrr        = (w + 1) % N;
      maddr[w]   = (maddr[w] + 1) % 128;
      mcred[w]   = mcred[w] - 1;
    end
    exp_busy = |(v & ~exp_ack);
    cp = int'(bus.credit_port);
    if (bus.credit_vld && cp < N) mcred[cp] = (mcred[cp] + 64 > 128) ? 128 : mcred[cp] + 64;
    if (bus.cfg_we && int'(bus.cfg_port) < N) begin
      mval[int'(bus.cfg_port)]  = 1;
      mdest[int'(bus.cfg_port)] = bus.cfg_dest;
    end
    if (!mpaused && bus.resend) mpaused = 1;
    else if (mpaused && !bus.resend) mpaused = 0;
    mprev = exp_ack;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("dout", 64'(bus.dout_leaf_interface2bft), 64'(exp_dout));
    check("ack",  64'(bus.ack_interface2user), 64'(exp_ack));
    check("busy", 64'(bus.busy), 64'(exp_busy));
    for (int p = 0; p < N; p++) gcnt[p] += int'(bus.ack_interface2user[p]);
  endtask

  task automatic clr_cnt();
    for (int p = 0; p < N; p++) gcnt[p] = 0;
  endtask

  task automatic idle();
    bus.vld_user2interface = '0;
    bus.cfg_we     = 1'b0;
    bus.credit_vld = 1'b0;
    bus.resend     = 1'b0;
  endtask

  task automatic set_din(input int p, input logic [31:0] d);
    bus.din_leaf_user2interface[p*PB +: PB] = d;
  endtask

  task automatic rand_din();
    for (int p = 0; p < N; p++) set_din(p, $urandom);
  endtask

  task automatic cfg(input int p, input logic [8:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_port = 4'(p);
    bus.cfg_dest = d;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
    check("rst_ack",  64'(bus.ack_interface2user), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    model_reset();
    mprev = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp4;
    reset = 1'b1;
    idle();
    bus.din_leaf_user2interface = '0;
    bus.cfg_port    = '0;
    bus.cfg_dest    = '0;
    bus.credit_port = '0;
    pkt0 = {1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF};
    clr_cnt();
    #2;
    do_reset();

    // single port: packet format, one-cycle ack, alternate-cycle grants
    cfg(0, {5'd3, 4'd2});
    set_din(0, 32'hDEADBEEF);
    bus.vld_user2interface = 5'b00001;
    step();
    check("pkt0", 64'(bus.dout_leaf_interface2bft), 64'(pkt0));
    check("ack0", 64'(bus.ack_interface2user), 64'd1);
    step();
    check("ack0_gap", 64'(bus.ack_interface2user), 64'd0);
    step();
    check("addr1", 64'(bus.dout_leaf_interface2bft[38:32]), 64'd1);
    bus.vld_user2interface = '0;
    step();

    // ports 0,2,4 held: one grant every cycle
    cfg(2, {5'd7, 4'd1});
    cfg(4, {5'd20, 4'd15});
    bus.vld_user2interface = 5'b10101;
    clr_cnt();
    repeat (9) begin rand_din(); step(); end
`ifdef LEAF_ARB_FIXED_PRIO_EN
    exp4 = 0;
`else
    exp4 = 3;
`endif
    check("no_gap", 64'(gcnt[0] + gcnt[2] + gcnt[4]), 64'd9);
    check("port4_share", 64'(gcnt[4]), 64'(exp4));
    bus.vld_user2interface = '0;
    step();

    // credits: 128 then block, +64, saturation at 128
    cfg(1, {5'd1, 4'd1});
    bus.vld_user2interface = 5'b00010;
    clr_cnt();
    repeat (262) begin rand_din(); step(); end
    check("cred_exhaust", 64'(gcnt[1]), 64'd128);
    check("busy_blocked", 64'(bus.busy), 64'd1);
    bus.credit_vld = 1'b1; bus.credit_port = 4'd1;
    step();
    bus.credit_vld = 1'b0;
    repeat (200) step();
    check("cred_plus64", 64'(gcnt[1]), 64'd192);
    bus.vld_user2interface = '0;
    bus.credit_vld = 1'b1;
    repeat (3) step();
    bus.credit_vld = 1'b0;
    bus.vld_user2interface = 5'b00010;
    repeat (300) step();
    check("cred_sat", 64'(gcnt[1]), 64'd320);
    bus.vld_user2interface = '0;
    step();

    // resend pause
    bus.vld_user2interface = 5'b10101;
    bus.resend = 1'b1;
    repeat (5) begin
      step();
      check("pause_ack", 64'(bus.ack_interface2user), 64'd0);
      check("pause_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
    end
    bus.resend = 1'b0;
    step();
    step();
    check("resume_grant", 64'(|bus.ack_interface2user), 64'd1);
    bus.vld_user2interface = '0;
    step();

    // unconfigured port 3, ignored out-of-range write, then configure
    bus.vld_user2interface = 5'b01000;
    clr_cnt();
    repeat (4) step();
    check("p3_unconfigured", 64'(gcnt[3]), 64'd0);
    bus.cfg_we = 1'b1; bus.cfg_port = 4'd9; bus.cfg_dest = 9'h1A5;
    step();
    bus.cfg_we = 1'b0;
    step();
    check("cfg9_ignored", 64'(gcnt[3]), 64'd0);
    cfg(3, {5'd9, 4'd3});
    step();
    check("p3_granted", 64'(bus.ack_interface2user), 64'b01000);
    bus.vld_user2interface = '0;
    step();

    // randomized traffic
    repeat (500) begin
      rand_din();
      bus.vld_user2interface = 5'($urandom);
      bus.cfg_we      = ($urandom % 16) == 0;
      bus.cfg_port    = 4'($urandom_range(0, 15));
      bus.cfg_dest    = 9'($urandom);
      bus.credit_vld  = ($urandom % 4) == 0;
      bus.credit_port = 4'($urandom_range(0, 7));
      bus.resend      = ($urandom % 16) == 0;
      step();
    end
    idle();
    step();

    // address wrap, then reset mid-stream
    bus.vld_user2interface = 5'b00001;
    bus.credit_port = 4'd0;
    bus.credit_vld  = 1'b1;
    n = 0;
    while (maddr[0] != 127 && n < 600) begin rand_din(); step(); n++; end
    n = 0;
    do begin step(); n++; end while (!bus.ack_interface2user[0] && n < 10);
    check("wrap_ack", 64'(bus.ack_interface2user[0]), 64'd1);
    check("addr127", 64'(bus.dout_leaf_interface2bft[38:32]), 64'd127);
    step();
    step();
    check("addr_wrap0", 64'(bus.dout_leaf_interface2bft[38:32]), 64'd0);
    bus.credit_vld = 1'b0;
    do_reset();
    cfg(0, {5'd3, 4'd2});
    clr_cnt();
    step();
    check("restart_ack", 64'(bus.ack_interface2user), 64'd1);
    check("restart_addr", 64'(bus.dout_leaf_interface2bft[38:32]), 64'd0);
    repeat (262) step();
    check("restart_cred", 64'(gcnt[0]), 64'd128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Shares the single 49-bit leaf-to-BFT output link between NUM_OUT_PORTS user output streams, each using a vld/ack handshake.
- Sits between the user kernel outputs and the BFT output of a leaf shell, in the clk_400 domain.
- Each accepted word is packetised with a per-port destination (leaf, port), taken from a runtime config table, plus a per-port 7-bit sequence address.
- Destination buffer space is tracked with per-port credit counters; the arbiter is round-robin.

Parameters:
- PACKET_BITS, 49, output packet width.
- PAYLOAD_BITS, 32, user data width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, sequence address field width.
- NUM_OUT_PORTS, 5, number of user output streams.
- NUM_BRAM_ADDR_BITS, 7, destination FIFO depth is 2^N words; this is the credit reset value.
- FREESPACE_UPDATE_SIZE, 64, credits returned per credit update.

Ports:
- clk  in  1  the only clock (400 MHz link clock).
- reset  in  1  asynchronous, active-low reset.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user data; port i at [i*32 +: 32].
- vld_user2interface  in  NUM_OUT_PORTS  per-port data valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port one-cycle accept pulse.
- cfg_we  in  1  destination table write strobe.
- cfg_port  in  NUM_PORT_BITS  table index (0-based output port).
- cfg_dest  in  NUM_LEAF_BITS+NUM_PORT_BITS  {dest_leaf, dest_port}.
- credit_vld  in  1  credit return strobe.
- credit_port  in  NUM_PORT_BITS  port receiving FREESPACE_UPDATE_SIZE credits.
- resend  in  1  link pause request.
- dout_leaf_interface2bft  out  PACKET_BITS  packet to BFT; bit 48 is the valid bit.
- busy  out  1  high while any port has vld asserted and was not granted this cycle.

Behaviour:
- Reset (reset==0):
  - all ack = 0, dout = 0, busy = 0.
  - rr pointer = 0; all sequence addresses = 0.
  - all credits = 2^NUM_BRAM_ADDR_BITS (128); all table entries invalid; state = RUN.
- Packet format: [48] = 1, [47:43] dest_leaf, [42:39] dest_port, [38:32] addr, [31:0] payload.
- Config table:
  - cfg_we writes entry cfg_port and sets its valid bit; takes effect next cycle.
  - cfg_port >= NUM_OUT_PORTS is ignored.
  - A write to a port granted in the same cycle does not affect that packet.
- Eligibility of port i in a cycle:
  - vld[i] = 1, table valid, credit[i] > 0, and ack[i] was not high in the previous cycle.
  - The last condition prevents a duplicate grant while the user advances its data.
- FSM:
  - RUN: on each posedge with at least one eligible port, grant the first eligible port at or after rr pointer, wrapping modulo NUM_OUT_PORTS.
    - The grant registers dout = packet(winner) and ack[winner] = 1 for exactly one cycle, so latency is 1 cycle from sampled vld to dout/ack.
    - Then rr = winner+1 (wraps), addr[winner] += 1 (wraps 127 -> 0), credit[winner] -= 1.
    - No eligible port: dout = 0, ack = 0.
    - resend = 1 moves to PAUSE with no grant that cycle.
  - PAUSE: dout = 0, ack = 0, no state changes except config and credits; resend = 0 returns to RUN.
- Throughput: up to 1 packet/cycle aggregate; a single port at most 1 packet every 2 cycles.
- Credits:
  - credit_vld adds FREESPACE_UPDATE_SIZE to credit[credit_port], saturating at 128.
  - A simultaneous grant decrement on the same port nets (+64-1, then saturate).
  - credit_port out of range is ignored.
  - credit = 0 blocks the port; other ports continue.
- Reset mid-operation clears everything immediately; an in-flight dout/ack is dropped.

Optional Feature:
- LEAF_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index eligible port always wins, and the rr pointer is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, program port0 -> (leaf 3, port 2), hold vld0 with 0xDEADBEEF -> next cycle dout = {1,5'd3,4'd2,7'd0,32'hDEADBEEF}, ack0 one cycle; second word has addr 1; single port grants alternate cycles.
- Ports 0, 2, 4 configured, all vld held -> grant order 0, 2, 4, 0, ... one grant per cycle with no gaps; with LEAF_ARB_FIXED_PRIO_EN grants 0, 2, 0, 2 (port 4 starved).
- Port1 sends 128 words with no credit return -> 129th blocked, busy = 1; credit_vld for port1 -> exactly 64 more accepted; credit_vld at 128 stays 128.
- resend asserted for 5 cycles with vld held -> dout = 0 and ack = 0 throughout, no addr/credit change; first grant on the cycle after resend falls.
- vld on an unconfigured port3 -> never acked; cfg_we port3 -> granted next eligible cycle; cfg_port = 9 write ignored.
- Assert reset mid-stream after addr reaches 127 (next wraps to 0) -> dout/ack 0 immediately, credits 128, addr 0 on restart.
